// File: rtl/chime_alarm_ctrl_if.sv
// ---------------------------------------------------------------------------
// chime_alarm_ctrl_if
//   Groups the time/alarm inputs, the user controls and the buzzer outputs
//   of the chime/alarm stage into one bundle.
//   master : time source / mode FSM side (drives time, alarm setting, keys;
//            observes the buzzer outputs)
//   slave  : chime_alarm_ctrl (consumes inputs, drives beep and status)
// Signals
//   hour, min, sec        current time of day (0..23, 0..59, 0..59)
//   alarm_hour, alarm_min stored alarm setting
//   alarm_en              alarm armed
//   adjusting             mode FSM not in NORMAL, blocks new triggers
//   alarm_off_pulse       one-cycle debounced alarm-off key event
//   beep                  buzzer drive
//   chime_active          hourly chime sounding
//   alarm_active          alarm sounding
// ---------------------------------------------------------------------------
interface chime_alarm_ctrl_if;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       adjusting;
  logic       alarm_off_pulse;
  logic       beep;
  logic       chime_active;
  logic       alarm_active;

  modport master (
    output hour, min, sec, alarm_hour, alarm_min, alarm_en, adjusting,
           alarm_off_pulse,
    input  beep, chime_active, alarm_active
  );

  modport slave (
    input  hour, min, sec, alarm_hour, alarm_min, alarm_en, adjusting,
           alarm_off_pulse,
    output beep, chime_active, alarm_active
  );
endinterface

// File: rtl/chime_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// chime_alarm_ctrl
//   Audible-output stage of the digital clock. Sounds a fixed-length chime at
//   every HH:00:00 and an alarm tone at alarm_hour:alarm_min:00 that lasts
//   until the alarm-off key is pressed or a number of seconds have elapsed.
//   The buzzer is driven with a square-wave tone (TONE_EN=1) or a steady
//   level (TONE_EN=0).
// Ports
//   clk    system clock
//   rst_n  asynchronous, active-low reset
//   bus    chime_alarm_ctrl_if.slave (time, alarm setting, keys, outputs)
// ---------------------------------------------------------------------------
module chime_alarm_ctrl #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int TONE_HZ         = 2_000,
  parameter int TONE_EN         = 1,
  parameter int CHIME_MS        = 500,
  parameter int ALARM_TIMEOUT_S = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  chime_alarm_ctrl_if.slave bus
);

  localparam int CHIME_CYC = CHIME_MS * (CLK_FREQ / 1000);
  localparam int HALF_CYC  = CLK_FREQ / (2 * TONE_HZ);

  // Every counter is sized to hold its own limit; degenerate limits still
  // get a one-bit counter.
  localparam int CW = (CHIME_CYC       < 1) ? 1 : $clog2(CHIME_CYC + 1);
  localparam int TW = (HALF_CYC        < 1) ? 1 : $clog2(HALF_CYC + 1);
  localparam int SW = (ALARM_TIMEOUT_S < 1) ? 1 : $clog2(ALARM_TIMEOUT_S + 1);

  localparam logic [CW-1:0] CHIME_LAST = CW'(CHIME_CYC - 1);
  localparam logic [CW-1:0] CHIME_MAX  = CW'(CHIME_CYC);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYC - 1);
  localparam logic [SW-1:0] TO_LAST    = SW'(ALARM_TIMEOUT_S - 1);
  localparam logic [SW-1:0] TO_MAX     = SW'(ALARM_TIMEOUT_S);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHIME = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  state_t          state_q,        state_d;
  logic [5:0]      prev_sec_q,     prev_sec_d;
  logic [CW-1:0]   chime_cnt_q,    chime_cnt_d;
  logic [SW-1:0]   sec_cnt_q,      sec_cnt_d;
  logic [TW-1:0]   tone_cnt_q,     tone_cnt_d;
  logic            tone_phase_q,   tone_phase_d;
  logic            beep_q,         beep_d;
  logic            chime_active_q, chime_active_d;
  logic            alarm_active_q, alarm_active_d;

  logic            sec_evt_s;
  logic            live_s;
  logic            chime_hit_s;
  logic            alarm_hit_s;
  logic            entry_s;

  // Second-event detection and trigger qualification.
  always_comb begin
    prev_sec_d  = bus.sec;
    // Any change of the seconds value counts, including forced jumps.
    sec_evt_s   = (bus.sec != prev_sec_q);
    live_s      = sec_evt_s && !bus.adjusting;
    chime_hit_s = live_s && (bus.min == 6'd0) && (bus.sec == 6'd0);
    alarm_hit_s = live_s && bus.alarm_en &&
                  (bus.hour == bus.alarm_hour) &&
                  (bus.min  == bus.alarm_min) &&
                  (bus.sec  == 6'd0);
  end

  // Next-state logic: alarm outranks chime; alarm-off outranks everything in ALARM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (alarm_hit_s) begin
          state_d = S_ALARM;
        end else if (chime_hit_s) begin
          state_d = S_CHIME;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHIME: begin
        if (alarm_hit_s) begin
          state_d = S_ALARM;
        end else if (bus.alarm_off_pulse) begin
          state_d = S_IDLE;
        end else if (chime_cnt_q >= CHIME_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CHIME;
        end
      end
      S_ALARM: begin
        if (bus.alarm_off_pulse) begin
          state_d = S_IDLE;
        end else if (sec_evt_s && (sec_cnt_q >= TO_LAST)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ALARM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Duration, timeout and tone counters; all clear on entry to a sounding state.
  always_comb begin
    chime_cnt_d  = chime_cnt_q;
    sec_cnt_d    = sec_cnt_q;
    tone_cnt_d   = tone_cnt_q;
    tone_phase_d = tone_phase_q;
    entry_s      = (state_d != state_q);
    if ((state_d == S_IDLE) || entry_s) begin
      chime_cnt_d  = {CW{1'b0}};
      sec_cnt_d    = {SW{1'b0}};
      tone_cnt_d   = {TW{1'b0}};
      tone_phase_d = 1'b0;
    end else begin
      if ((state_q == S_CHIME) && (chime_cnt_q != CHIME_MAX)) begin
        chime_cnt_d = chime_cnt_q + 1'b1;
      end else begin
        chime_cnt_d = chime_cnt_q;
      end
      // A re-hit in ALARM does not touch this count, so the timeout is not restarted.
      if ((state_q == S_ALARM) && sec_evt_s && (sec_cnt_q != TO_MAX)) begin
        sec_cnt_d = sec_cnt_q + 1'b1;
      end else begin
        sec_cnt_d = sec_cnt_q;
      end
      if (tone_cnt_q >= HALF_LAST) begin
        tone_cnt_d   = {TW{1'b0}};
        tone_phase_d = ~tone_phase_q;
      end else begin
        tone_cnt_d   = tone_cnt_q + 1'b1;
        tone_phase_d = tone_phase_q;
      end
    end
  end

  // Output values, decoded from the next state so the pins are registered.
  always_comb begin
    beep_d         = 1'b0;
    chime_active_d = (state_d == S_CHIME);
    alarm_active_d = (state_d == S_ALARM);
    if (state_d != S_IDLE) begin
      beep_d = (TONE_EN != 0) ? tone_phase_d : 1'b1;
    end else begin
      beep_d = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      prev_sec_q     <= 6'd0;
      chime_cnt_q    <= {CW{1'b0}};
      sec_cnt_q      <= {SW{1'b0}};
      tone_cnt_q     <= {TW{1'b0}};
      tone_phase_q   <= 1'b0;
      beep_q         <= 1'b0;
      chime_active_q <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_sec_q     <= prev_sec_d;
      chime_cnt_q    <= chime_cnt_d;
      sec_cnt_q      <= sec_cnt_d;
      tone_cnt_q     <= tone_cnt_d;
      tone_phase_q   <= tone_phase_d;
      beep_q         <= beep_d;
      chime_active_q <= chime_active_d;
      alarm_active_q <= alarm_active_d;
    end
  end

  assign bus.beep         = beep_q;
  assign bus.chime_active = chime_active_q;
  assign bus.alarm_active = alarm_active_q;

endmodule
